// File: rtl/ram_sum_reader.sv
// Reads N words from a synchronous-read RAM, sums them modulo 2^32, writes the sum back to wb_addr.
// One word per cycle; result pulse (done) N+3 cycles after start, or 2 cycles for an empty job.
module ram_sum_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic [10:0] count,
  input  logic [9:0]  wb_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        overflow,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  state_t      state, state_nxt;
  logic [10:0] eff_cnt;
  logic [10:0] remain;
  logic [9:0]  wb_q;
  logic [31:0] acc;
  logic        rd_vld;
  logic [32:0] acc_add;

  assign eff_cnt = (count > 11'd1024) ? 11'd1024 : count;
  assign acc_add = {1'b0, acc} + {1'b0, ram_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (eff_cnt == 11'd0) ? WRITE : ISSUE;
      ISSUE:   if (remain == 11'd1) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    ram_we    = (state == WRITE);
    ram_wdata = (state == WRITE) ? acc : 32'd0;
  end

  // rd_vld marks the cycle in which the word addressed one cycle earlier sits on ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain   <= '0;
      wb_q     <= '0;
      acc      <= '0;
      rd_vld   <= 1'b0;
      ram_addr <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      rd_vld <= (state == ISSUE);
      if (rd_vld) begin
        acc <= acc_add[31:0];
        if (acc_add[32]) overflow <= 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          remain   <= eff_cnt;
          wb_q     <= wb_addr;
          acc      <= '0;
          overflow <= 1'b0;
          ram_addr <= (eff_cnt == 11'd0) ? wb_addr : base_addr;
        end
        ISSUE: begin
          remain <= remain - 11'd1;
          if (remain != 11'd1) ram_addr <= ram_addr + 10'd1;
        end
        DRAIN: ram_addr <= wb_q;
        WRITE: sum <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sum_reader.sv
// Directed bench for ram_sum_reader with a 1024x32 synchronous-read RAM and a cycle-level expectation queue.
module tb_ram_sum_reader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic [9:0]  wb_addr;
  logic        busy, done, overflow, ram_we;
  logic [31:0] sum, ram_wdata, ram_rdata;
  logic [9:0]  ram_addr;

  logic        tb_we;
  logic [9:0]  tb_addr;
  logic [31:0] tb_wdata;
  logic [31:0] mem   [1024];
  logic [31:0] mem_m [1024];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_sum;
  logic        last_ovf;

  typedef struct {
    logic        busy;
    logic        done;
    logic        we;
    logic        achk;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  ram_sum_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .wb_addr(wb_addr), .busy(busy), .done(done), .sum(sum), .overflow(overflow),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic w, input logic ac,
                              input logic [9:0] a, input logic [31:0] wd,
                              input logic [31:0] s, input logic o);
    exp_t e;
    e.busy = b; e.done = d; e.we = w; e.achk = ac;
    e.addr = a; e.wdata = wd; e.sum = s; e.ovf = o;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_sum", sum, 0);
      chk("rst_ovf", 32'(overflow), 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("ram_we", 32'(ram_we), 32'(e.we));
      chk("ram_wdata", ram_wdata, e.wdata);
      if (e.achk) chk("ram_addr", 32'(ram_addr), 32'(e.addr));
      if (e.done) begin
        chk("sum", sum, e.sum);
        chk("overflow", 32'(overflow), 32'(e.ovf));
      end
    end else begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_we", 32'(ram_we), 0);
      chk("idle_wdata", ram_wdata, 0);
      chk("idle_sum", sum, last_sum);
      chk("idle_ovf", 32'(overflow), 32'(last_ovf));
    end
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
    mem_m[a] = d;
  endtask

  // Expected per-cycle behaviour of one job, cycle 1 being the one after the accepting edge.
  task automatic model_push(input logic [9:0] b, input logic [10:0] c, input logic [9:0] w,
                            output int n, output logic [31:0] s);
    logic [63:0] tot;
    logic [9:0]  a;
    logic        o;
    n = (c > 11'd1024) ? 1024 : int'(c);
    tot = 0;
    for (int i = 0; i < n; i++) begin
      a = b + 10'(i);
      tot += 64'(mem_m[a]);
    end
    s = tot[31:0];
    o = (tot[63:32] != 0);
    for (int k = 1; k <= n; k++) exp_q.push_back(mk(1, 0, 0, 1, b + 10'(k - 1), 0, 0, 0));
    if (n > 0) exp_q.push_back(mk(1, 0, 0, 1, b + 10'(n - 1), 0, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 1, w, s, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 1, w, 0, s, o));
    last_sum = s;
    last_ovf = o;
  endtask

  task automatic run_job(input logic [9:0] b, input logic [10:0] c, input logic [9:0] w,
                         input int stray_at, output int lat,
                         output logic [31:0] gsum, output logic gov);
    int          n;
    logic [31:0] s;
    @(negedge clk);
    base_addr = b; count = c; wb_addr = w; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_push(b, c, w, n, s);
    mem_m[w] = s;
    lat = 0; gsum = 0; gov = 0;
    for (int k = 1; k <= n + 20; k++) begin
      @(negedge clk);
      if (k == stray_at) begin
        start = 1'b1; base_addr = 10'h3ff; count = 11'd3; wb_addr = 10'd9;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = k; gsum = sum; gov = overflow;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int          lat;
    logic [31:0] gs;
    logic        go;
    int          nn;
    logic [31:0] ss;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; wb_addr = '0;
    tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    last_sum = 0; last_ovf = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    poke(10, 1); poke(11, 2); poke(12, 3); poke(13, 4);
    run_job(10, 4, 100, 0, lat, gs, go);
    chk("s1_lat", 32'(lat), 7);
    chk("s1_sum", gs, 10);
    chk("s1_ovf", 32'(go), 0);
    @(negedge clk);
    chk("s1_ram100", mem[100], 10);

    poke(1022, 5); poke(1023, 6); poke(0, 7);
    run_job(1022, 3, 500, 0, lat, gs, go);
    chk("s2_sum", gs, 18);
    chk("s2_lat", 32'(lat), 6);

    poke(0, 32'hFFFF_FFFF); poke(1, 2);
    run_job(0, 2, 501, 0, lat, gs, go);
    chk("s3_sum", gs, 1);
    chk("s3_ovf", 32'(go), 1);

    poke(5, 32'hDEAD);
    run_job(7, 0, 5, 0, lat, gs, go);
    chk("s4_lat", 32'(lat), 2);
    @(negedge clk);
    chk("s4_ram5", mem[5], 0);

    for (int i = 0; i < 1024; i++) poke(10'(i), 1);
    run_job(0, 2000, 200, 0, lat, gs, go);
    chk("s5_lat", 32'(lat), 1027);
    chk("s5_sum", gs, 1024);
    chk("s5_ovf", 32'(go), 0);

    poke(600, 7);
    @(negedge clk);
    base_addr = 300; count = 50; wb_addr = 600; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_push(300, 50, 600, nn, ss);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(ram_we), 0);
    last_sum = 0; last_ovf = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("abort_ram600", mem[600], 7);
    run_job(1020, 8, 600, 3, lat, gs, go);
    chk("s6_sum", gs, 8);
    chk("s6_lat", 32'(lat), 11);
    repeat (4) @(negedge clk);
    chk("s6_ram600", mem[600], 8);
    chk("s6_ram9", mem[9], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
